// File: rtl/mem_arbiter.sv
// Byte-wide memory bus sequencer shared by instruction fetch and load/store.
// Splits 1/2/4-byte requests into byte cycles and handles read latency, I/O throttling and bus freeze.
module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        ls_req_in,
  input  logic        ls_wr_in,
  input  logic [1:0]  ls_size_in,
  input  logic [31:0] ls_addr_in,
  input  logic [31:0] ls_wdata_in,
  output logic        ls_done_out,
  output logic [31:0] ls_rdata_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester raises req (level) with stable fields and holds it
  // until its done pulses; done lasts exactly one cycle and the data output
  // keeps its value until that requester's next done.

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, IOWAIT = 2'd3} state_t;

  state_t      state;
  logic [31:0] addr_q, wdata_q, buf_q, cap_buf, wnext_addr, new_addr;
  logic [2:0]  n_q, iss, cap, wnext, new_n;
  logic        owner_q, last_q, issued_q, pend_q, rdy_q, wr_q;
  logic        if_ok, ls_ok, grant_ls, accept, new_wr;

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == IO_HI;
  endfunction

  assign mem_wr    = wr_q & rdy_in;
  assign dbg_state = state;

  always_comb begin
    if_ok    = if_req_in & ~clear_in;
    ls_ok    = ls_req_in & (~clear_in | ls_wr_in);
    // last_q: 0 = IF served last, 1 = LS served last
    grant_ls = ls_ok & (~if_ok | ~last_q);
    accept   = (state == IDLE) & (if_ok | ls_ok);
    new_addr = grant_ls ? ls_addr_in : if_addr_in;
    new_wr   = grant_ls & ls_wr_in;
    new_n    = 3'd4;
    if (grant_ls) begin
      case (ls_size_in)
        2'd0:    new_n = 3'd1;
        2'd1:    new_n = 3'd2;
        default: new_n = 3'd4;
      endcase
    end
    wnext      = iss + 3'd1;
    wnext_addr = addr_q + {29'd0, wnext};
    cap_buf    = buf_q;
    cap_buf[{cap[1:0], 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      n_q          <= '0;
      iss          <= '0;
      cap          <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b0;
      issued_q     <= 1'b0;
      pend_q       <= 1'b0;
      rdy_q        <= 1'b1;
      wr_q         <= 1'b0;
      mem_a        <= '0;
      mem_dout     <= '0;
      if_done_out  <= 1'b0;
      if_data_out  <= '0;
      ls_done_out  <= 1'b0;
      ls_rdata_out <= '0;
    end else begin
      rdy_q <= rdy_in;
      // With rdy_in low everything freezes; mem_wr is gated combinationally.
      if (rdy_in) begin
        if_done_out <= 1'b0;
        ls_done_out <= 1'b0;
        case (state)
          IDLE: begin
            mem_a    <= '0;
            mem_dout <= '0;
            wr_q     <= 1'b0;
            if (accept) begin
              addr_q   <= new_addr;
              wdata_q  <= grant_ls ? ls_wdata_in : 32'd0;
              n_q      <= new_n;
              owner_q  <= grant_ls;
              cap      <= '0;
              buf_q    <= '0;
              pend_q   <= 1'b0;
              if (new_wr) begin
                iss      <= '0;
                issued_q <= 1'b0;
                if (is_io(new_addr) && io_buffer_full) begin
                  state <= IOWAIT;
                end else begin
                  state    <= WRITE;
                  mem_a    <= new_addr;
                  mem_dout <= ls_wdata_in[7:0];
                  wr_q     <= 1'b1;
                end
              end else begin
                state    <= READ;
                mem_a    <= new_addr;
                iss      <= 3'd1;
                issued_q <= 1'b1;
              end
            end
          end

          READ: begin
            if (clear_in) begin
              state    <= IDLE;
              mem_a    <= '0;
              iss      <= '0;
              cap      <= '0;
              issued_q <= 1'b0;
              pend_q   <= 1'b0;
            end else if (!rdy_q) begin
              // Bytes in flight across a freeze are lost: restart at the oldest uncaptured one.
              mem_a    <= addr_q + {29'd0, cap};
              iss      <= cap + 3'd1;
              issued_q <= 1'b1;
              pend_q   <= 1'b0;
            end else begin
              pend_q <= issued_q;
              if (iss < n_q) begin
                mem_a    <= addr_q + {29'd0, iss};
                iss      <= iss + 3'd1;
                issued_q <= 1'b1;
              end else begin
                mem_a    <= '0;
                issued_q <= 1'b0;
              end
              if (pend_q) begin
                buf_q <= cap_buf;
                cap   <= cap + 3'd1;
                if (cap == n_q - 3'd1) begin
                  state    <= IDLE;
                  mem_a    <= '0;
                  iss      <= '0;
                  cap      <= '0;
                  issued_q <= 1'b0;
                  pend_q   <= 1'b0;
                  last_q   <= owner_q;
                  if (owner_q) begin
                    ls_done_out  <= 1'b1;
                    ls_rdata_out <= cap_buf;
                  end else begin
                    if_done_out <= 1'b1;
                    if_data_out <= cap_buf;
                  end
                end
              end
            end
          end

          WRITE: begin
            if (wnext == n_q) begin
              state       <= IDLE;
              mem_a       <= '0;
              mem_dout    <= '0;
              wr_q        <= 1'b0;
              iss         <= '0;
              last_q      <= owner_q;
              ls_done_out <= 1'b1;
            end else if (is_io(wnext_addr) && io_buffer_full) begin
              state    <= IOWAIT;
              mem_a    <= '0;
              mem_dout <= '0;
              wr_q     <= 1'b0;
              iss      <= wnext;
            end else begin
              mem_a    <= wnext_addr;
              mem_dout <= wdata_q[{wnext[1:0], 3'b000} +: 8];
              wr_q     <= 1'b1;
              iss      <= wnext;
            end
          end

          IOWAIT: begin
            if (!io_buffer_full) begin
              state    <= WRITE;
              mem_a    <= addr_q + {29'd0, iss};
              mem_dout <= wdata_q[{iss[1:0], 3'b000} +: 8];
              wr_q     <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
